// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and constants for the PicoRV32-to-UART memory bridge:
// FSM states, command-byte layout and fixed response words.
package uart_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        SEND_DATA,
        WAIT_RESP,
        DONE
    } state_e;

    localparam int          CmdWriteBit    = 7;
    localparam int          CmdInstrBit    = 6;
    localparam logic [7:0]  AckByteDefault = 8'hAA;
    localparam logic [31:0] ReadErrWord    = 32'hFFFF_FFFF;

    // Command byte: {write, instr, 2'b00, wstrb}; a write is any non-zero strobe.
    function automatic logic [7:0] cmd_byte(input logic instr, input logic [3:0] wstrb);
        logic [7:0] b;
        b              = {4'b0000, wstrb};
        b[CmdWriteBit] = |wstrb;
        b[CmdInstrBit] = instr;
        return b;
    endfunction

endpackage

// File: rtl/uart_mem_bridge_if.sv
// Core memory port plus UART byte channels seen by the bridge.
// slave = the bridge itself, master = the core/UART environment around it.
interface uart_mem_bridge_if;
    logic        mem_valid_i;
    logic        mem_instr_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic        mem_ready_o;
    logic [31:0] mem_rdata_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        timeout_o;
    logic        proto_err_o;

    modport slave (
        input  mem_valid_i, mem_instr_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
        input  tx_ready_i, rx_data_i, rx_valid_i,
        output mem_ready_o, mem_rdata_o, tx_data_o, tx_valid_o, timeout_o, proto_err_o
    );

    modport master (
        output mem_valid_i, mem_instr_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
        output tx_ready_i, rx_data_i, rx_valid_i,
        input  mem_ready_o, mem_rdata_o, tx_data_o, tx_valid_o, timeout_o, proto_err_o
    );
endinterface

// File: rtl/uart_mem_bridge.sv
// Serialises one PicoRV32 memory access at a time onto the UART byte stream
// and assembles the host's reply, aborting with an error word on timeout.
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int         ClkFreq       = 12000000,
    parameter int         TimeoutCycles = ClkFreq / 10,
    parameter logic [7:0] AckByte       = AckByteDefault
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    uart_mem_bridge_if.slave   bus
);

    localparam int TimerW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [31:0]         addr_q, wdata_q;
    logic [3:0]          wstrb_q;
    logic                instr_q;
    logic                latch_en;

    logic                tx_valid, mem_ready, timeout, proto_err;
    logic [7:0]          tx_data;
    logic [31:0]         mem_rdata;

    logic                is_write;
    assign is_write = |wstrb_q;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        latch_en  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        timeout   = 1'b0;
        proto_err = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.mem_valid_i && !mem_ready) begin
                    latch_en = 1'b1;
                    rdata_d  = 32'h0;
                    err_d    = 1'b0;
                    state_d  = SEND_CMD;
                end
            end
            SEND_CMD: begin
                tx_valid = 1'b1;
                tx_data  = cmd_byte(instr_q, wstrb_q);
                if (bus.tx_ready_i) begin
                    cnt_d   = 2'd0;
                    state_d = SEND_ADDR;
                end
            end
            SEND_ADDR, SEND_DATA: begin
                tx_valid = 1'b1;
                tx_data  = (state_q == SEND_ADDR) ? addr_q[{cnt_q, 3'b000} +: 8]
                                                  : wdata_q[{cnt_q, 3'b000} +: 8];
                if (bus.tx_ready_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        timer_d = '0;
                        state_d = (state_q == SEND_ADDR && is_write) ? SEND_DATA : WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                // A received byte always wins over an expiring timer.
                if (bus.rx_valid_i) begin
                    timer_d = '0;
                    if (is_write) begin
                        proto_err = (bus.rx_data_i != AckByte);
                        state_d   = DONE;
                    end else begin
                        rdata_d[{cnt_q, 3'b000} +: 8] = bus.rx_data_i;
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) state_d = DONE;
                    end
                end else if (timer_q == TimerW'(TimeoutCycles - 1)) begin
                    timeout = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            DONE: begin
                mem_ready = 1'b1;
                mem_rdata = err_q ? ReadErrWord : rdata_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            timer_q <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            instr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (latch_en) begin
                addr_q  <= bus.mem_addr_i;
                wdata_q <= bus.mem_wdata_i;
                wstrb_q <= bus.mem_wstrb_i;
                instr_q <= bus.mem_instr_i;
            end
        end
    end

    assign bus.tx_valid_o  = tx_valid;
    assign bus.tx_data_o   = tx_data;
    assign bus.mem_ready_o = mem_ready;
    assign bus.mem_rdata_o = mem_rdata;
    assign bus.timeout_o   = timeout;
    assign bus.proto_err_o = proto_err;

endmodule
